// File: rtl/seg_scan_controller.sv
// seg_scan_controller
//   Two-digit 7-segment scan sequencer. Each frame is BLANK0, SHOW0, BLANK1,
//   SHOW1. Every slot lasts CLK_DIV cycles: BLANK_CYCLES dark cycles, then the
//   digit is shown. Digit updates arrive over a valid/ready handshake into a
//   one-entry pending buffer. That buffer is copied into the displayed
//   (shadow) registers only at the frame boundary, the last cycle of SHOW1.
//
// Ports
//   clock, reset        system clock, asynchronous active-high reset
//   upd_valid/upd_ready update handshake (ready = pending buffer empty)
//   digit0, digit1      hex codes for anode a0 / a1
//   dig_en              per-digit enable (0 keeps that anode dark)
//   a0, a1              anodes, active-low
//   cathode             segments {a..g}, active-low
//   frame_done          one-cycle pulse on the frame boundary cycle
module seg_scan_controller #(
    parameter int unsigned CLK_DIV      = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       upd_valid,
    output logic       upd_ready,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [1:0] dig_en,
    output logic       a0,
    output logic       a1,
    output logic [6:0] cathode,
    output logic       frame_done
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {BLANK0, SHOW0, BLANK1, SHOW1} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic [3:0] pend_d0, pend_d1;
    logic [1:0] pend_en;
    logic [3:0] sh_d0, sh_d1;
    logic [1:0] sh_en;

    logic       a0_nx, a1_nx, fd_nx;
    logic [6:0] cath_nx;
    logic       boundary, take, apply;

    function automatic logic [6:0] seg_decode(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CNT_W'(1);
        case (state)
            BLANK0: if (cnt == BLANK_LAST) state_nx = SHOW0;
            SHOW0: if (cnt == SLOT_LAST) begin
                state_nx = BLANK1;
                cnt_nx   = '0;
            end
            BLANK1: if (cnt == BLANK_LAST) state_nx = SHOW1;
            SHOW1: if (cnt == SLOT_LAST) begin
                state_nx = BLANK0;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = BLANK0;
                cnt_nx   = '0;
            end
        endcase

        boundary = (state == SHOW1) && (cnt == SLOT_LAST);
        // upd_ready doubles as the "pending buffer empty" flag.
        apply    = boundary && !upd_ready;
        take     = upd_valid && upd_ready;

        // Pin values are computed for the upcoming state and registered, so
        // they are valid in the first cycle of each state. The shadow registers
        // change only when the next state is BLANK0, where the pins are dark
        // anyway, so the current shadow values are enough here.
        a0_nx   = 1'b1;
        a1_nx   = 1'b1;
        cath_nx = '1;
        case (state_nx)
            SHOW0: if (sh_en[0]) begin
                a0_nx   = 1'b0;
                cath_nx = seg_decode(sh_d0);
            end
            SHOW1: if (sh_en[1]) begin
                a1_nx   = 1'b0;
                cath_nx = seg_decode(sh_d1);
            end
            default: ;
        endcase
        fd_nx = (state_nx == SHOW1) && (cnt_nx == SLOT_LAST);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= BLANK0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            upd_ready <= 1'b1;
            pend_d0   <= '0;
            pend_d1   <= '0;
            pend_en   <= '0;
            sh_d0     <= '0;
            sh_d1     <= '0;
            sh_en     <= '0;
        end else begin
            if (apply) begin
                sh_d0     <= pend_d0;
                sh_d1     <= pend_d1;
                sh_en     <= pend_en;
                upd_ready <= 1'b1;
            end
            if (take) begin
                pend_d0   <= digit0;
                pend_d1   <= digit1;
                pend_en   <= dig_en;
                upd_ready <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a0         <= 1'b1;
            a1         <= 1'b1;
            cathode    <= '1;
            frame_done <= 1'b0;
        end else begin
            a0         <= a0_nx;
            a1         <= a1_nx;
            cathode    <= cath_nx;
            frame_done <= fd_nx;
        end
    end

endmodule
